// File: rtl/scan_uart_tx.sv
`default_nettype none
// ============================================================================
// scan_uart_tx : captures scan-chain TDO on RTCK rises, packs LSB-first bytes
//                into a 4-deep FIFO and sends them 8N1 on tx.
// Revision     : 1.0
// ============================================================================
module scan_uart_tx #(
  parameter int CLKRATE  = 12_000_000,
  parameter int BAUDRATE = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tms,
  input  logic       rtck,
  input  logic       tdo,
  output logic       tx,
  output logic       busy,
  output logic       overflow,
  output logic [2:0] fifo_level
);

  localparam int              DIVISOR   = CLKRATE / BAUDRATE;
  localparam int              BAUD_W    = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIVISOR - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Equal-depth synchronizers keep tdo aligned with the rtck edge detect.
  logic r_tms_s1, r_tms_s2;
  logic r_rtck_s1, r_rtck_s2, r_rtck_s3;
  logic r_tdo_s1, r_tdo_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tms_s1  <= 1'b0;
      r_tms_s2  <= 1'b0;
      r_rtck_s1 <= 1'b0;
      r_rtck_s2 <= 1'b0;
      r_rtck_s3 <= 1'b0;
      r_tdo_s1  <= 1'b0;
      r_tdo_s2  <= 1'b0;
    end else begin
      r_tms_s1  <= tms;
      r_tms_s2  <= r_tms_s1;
      r_rtck_s1 <= rtck;
      r_rtck_s2 <= r_rtck_s1;
      r_rtck_s3 <= r_rtck_s2;
      r_tdo_s1  <= tdo;
      r_tdo_s2  <= r_tdo_s1;
    end
  end

  logic       w_rise;
  logic       w_wr;
  logic [7:0] w_byte;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_cap;

  assign w_rise = r_rtck_s2 & ~r_rtck_s3;
  assign w_wr   = r_tms_s2 & w_rise & (r_bit_cnt == 3'd7);
  // The 8th bit goes straight into the FIFO word, so only 7 bits are held.
  assign w_byte = {r_tdo_s2, r_cap};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= 3'd0;
      r_cap     <= 7'd0;
    end else if (!r_tms_s2) begin
      r_bit_cnt <= 3'd0;
    end else if (w_rise) begin
      r_cap     <= {r_tdo_s2, r_cap[6:1]};
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  logic [7:0] r_mem [4];
  logic [1:0] r_wptr, r_rptr;
  logic [2:0] r_count;
  logic       r_overflow;
  logic       w_full, w_empty, w_pop, w_push;
  logic [7:0] w_head;

  assign w_full  = (r_count == 3'd4);
  assign w_empty = (r_count == 3'd0);
  // A pop in the same cycle frees the slot, so a write into a full FIFO survives.
  assign w_push  = w_wr & (~w_full | w_pop);
  assign w_head  = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= 2'd0;
      r_rptr     <= 2'd0;
      r_count    <= 3'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 2'd1;
      if (w_pop)  r_rptr <= r_rptr + 2'd1;
      r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
      if (w_wr & ~w_push) r_overflow <= 1'b1;
    end
  end

  state_t            r_state, w_state_nxt;
  logic [BAUD_W-1:0] r_baud, w_baud_nxt;
  logic [2:0]        r_bit_idx, w_bit_idx_nxt;
  logic [7:0]        r_shift, w_shift_nxt;
  logic              r_tx, w_tx_nxt;
  logic              w_baud_end;

  assign w_baud_end = (r_baud == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_baud_nxt    = w_baud_end ? '0 : r_baud + BAUD_W'(1);
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_pop         = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_state_nxt   = S_DATA;
          w_bit_idx_nxt = 3'd0;
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_shift_nxt   = {1'b0, r_shift[7:1]};
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          // Chain straight into the next start bit when data is waiting.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  assign tx         = r_tx;
  assign busy       = (r_state != S_IDLE) | ~w_empty;
  assign overflow   = r_overflow;
  assign fifo_level = r_count;

endmodule
`default_nettype wire

// File: doc/scan_uart_tx.md
# scan_uart_tx

Host-bound return path for the scan-chain test link. Samples the chain's returned test clock and test data output, packs captured bits into bytes LSB-first, buffers them in a 4-entry FIFO, and transmits them 8N1 on the serial line to the host COM port. It is the transmit counterpart of the receive-side UART that drives TCK/TDI from RX, and sits in the FPGA top level between the chain outputs (RTCK, TDO) and TX.

## Interface
- CLKRATE, 12_000_000, system clock frequency in Hz
- BAUDRATE, 115_200, serial bit rate; DIVISOR = CLKRATE / BAUDRATE, integer truncation (104 at defaults)

- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- tms  input  1  capture enable (test mode select, asynchronous to clk)
- rtck  input  1  returned test clock from chain (asynchronous)
- tdo  input  1  test data output from chain (asynchronous), valid at rtck rising edge
- tx  output  1  serial data to host, idle high
- busy  output  1  high while a frame is being sent or FIFO is non-empty
- overflow  output  1  sticky: a completed byte was dropped because FIFO was full
- fifo_level  output  3  current FIFO occupancy, 0..4

## Operation
- Synchronizers: tms, rtck, tdo each pass through 2 flops (equal depth, so tdo stays aligned with rtck); a third rtck flop provides edge detect. Rise = rtck_s2 & ~rtck_s3.
- Capture: on each rise while tms_s2 = 1, shift tdo_s2 into an 8-bit register at bit[bit_cnt] (LSB first), bit_cnt increments (3-bit, wraps 7→0).
- When the 8th bit is captured, the full byte is written to the FIFO on that same clock edge; bit_cnt returns to 0.
- tms_s2 = 0: bit_cnt forced to 0, partial byte discarded, rises ignored.
- FIFO: 4 entries, circular, 2-bit pointers plus count. Write when full: byte dropped, overflow set to 1, held until reset. Simultaneous write and pop when full: pop wins first, write accepted (no overflow).
- Transmitter FSM, states IDLE, START, DATA, STOP; baud counter counts 0..DIVISOR-1.
  - IDLE: tx = 1. If FIFO non-empty: pop head into tx shift register, go START, clear baud counter.
  - START: tx = 0 for DIVISOR cycles, then DATA.
  - DATA: tx = shift[0] for DIVISOR cycles per bit, shift right, 8 bits, then STOP.
  - STOP: tx = 1 for DIVISOR cycles. At end: if FIFO non-empty, pop and go directly to START (no idle gap); else IDLE.
- busy = (state != IDLE) | (fifo_level != 0).
- tx is a registered output (no combinational glitches).

## Timing
- Reset (asynchronous assert, synchronous release on clk): tx = 1, busy = 0, overflow = 0, fifo_level = 0, state IDLE, bit_cnt = 0, synchronizer flops cleared.
- Reset mid-frame: tx returns to 1 immediately; frame truncated, FIFO contents and partial byte lost.
- Input to capture latency: rtck rising pin edge to bit captured is 3 clk edges.
- Byte written at edge W (fifo_level increments at W). If FSM idle, pop at W+1, tx falls at W+1.
- Frame length exactly 10 × DIVISOR clk cycles; back-to-back frames contiguous.
- rtck high and low phases must each be ≥ 3 clk periods; tms changes must respect ≥ 3 clk setup to the next rtck rise. Sustained throughput must not exceed one byte per 10 × DIVISOR cycles or FIFO overflows.

## Test plan
- Reset: assert rst_n = 0 mid-frame -> tx = 1, busy = 0, overflow = 0, fifo_level = 0 within same cycle; after release tx stays 1 with no input activity.
- Single byte (CLKRATE = 1_000_000, BAUDRATE = 100_000, DIVISOR = 10): tms = 1, clock 8 rtck pulses with tdo = 1,0,1,0,0,1,0,1 -> fifo_level 1 then 0, tx = start 0, bits 1,0,1,0,0,1,0,1, stop 1, each 10 cycles, frame 100 cycles; byte value 0xA5.
- Partial discard: 5 bits captured, tms → 0, then tms = 1 and 8 bits of 0x3C -> only 0x3C transmitted.
- Back-to-back: 3 bytes 0x00, 0xFF, 0x55 captured in burst -> three contiguous 100-cycle frames, no idle gap, busy high throughout, then low.
- Overflow: 6 bytes captured faster than transmission (rtck period 8 clk) -> first byte sending, fifo_level reaches 4, 6th byte dropped, overflow = 1 and stays 1; transmitted sequence is bytes 1..5.
- Divisor truncation: CLKRATE = 12_000_000, BAUDRATE = 115_200 -> each bit exactly 104 cycles.
